// File: rtl/nanoproc_pkg.sv
// Shared nanoproc definitions: opcodes, register-bank geometry and the signed-overflow rule.
package nanoproc_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_ADD  = 2'd1,
        OP_SUB  = 2'd2,
        OP_MOVI = 2'd3
    } op_e;

    localparam int unsigned REG_AW   = 3;
    localparam int unsigned NUM_REGS = 8;

    // Two's-complement overflow from operand and result sign bits; SUB compares against ~B.
    function automatic logic signed_ovf(input logic sa, input logic sb, input logic ss,
                                        input logic sub);
        if (sub) begin
            return (sa != sb) && (ss != sa);
        end
        return (sa == sb) && (ss != sa);
    endfunction

endpackage

// File: rtl/register_bank.sv
// 8 x N register bank with R0 hard-wired to zero: two operand read ports, one debug
// read port and one write port.
module register_bank
    import nanoproc_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [REG_AW-1:0] i_ra_idx,
    output logic [N-1:0]      o_ra_data,
    input  logic [REG_AW-1:0] i_rb_idx,
    output logic [N-1:0]      o_rb_data,
    input  logic [REG_AW-1:0] i_dbg_idx,
    output logic [N-1:0]      o_dbg_data,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_wr_idx,
    input  logic [N-1:0]      i_wr_data
);

    logic [N-1:0] r_regs [NUM_REGS];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_wr_idx != '0)) begin
            r_regs[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_ra_data  = (i_ra_idx  == '0) ? '0 : r_regs[i_ra_idx];
    assign o_rb_data  = (i_rb_idx  == '0) ? '0 : r_regs[i_rb_idx];
    assign o_dbg_data = (i_dbg_idx == '0) ? '0 : r_regs[i_dbg_idx];

endmodule

// File: rtl/adder_issue_writeback.sv
// Issue/write-back stage around an external ripple-carry adder/subtractor.
// Define ADDER_BYPASS_EN to forward add_s to dependent requests instead of interlocking.
module adder_issue_writeback
    import nanoproc_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [REG_AW-1:0] in_ra,
    input  logic [REG_AW-1:0] in_rb,
    input  logic [N-1:0]      in_imm,
    input  logic              hold,
    output logic [N-1:0]      add_a,
    output logic [N-1:0]      add_b,
    output logic              add_sub,
    input  logic [N-1:0]      add_s,
    output logic              zero,
    output logic              ovf,
    input  logic [REG_AW-1:0] dbg_sel,
    output logic [N-1:0]      dbg_data
);

    logic              r_e_valid;
    logic              r_e_sub;
    logic [REG_AW-1:0] r_e_rd;
    logic [N-1:0]      r_e_a;
    logic [N-1:0]      r_e_b;
    logic              r_zero;
    logic              r_ovf;

    logic [N-1:0]      w_bank_a;
    logic [N-1:0]      w_bank_b;
    logic [N-1:0]      w_opnd_a;
    logic [N-1:0]      w_opnd_b;
    logic              w_accept;
    logic              w_is_movi;

    register_bank #(
        .N (N)
    ) u_bank (
        .i_clk      (clk),
        .i_rst      (reset),
        .i_ra_idx   (in_ra),
        .o_ra_data  (w_bank_a),
        .i_rb_idx   (in_rb),
        .o_rb_data  (w_bank_b),
        .i_dbg_idx  (dbg_sel),
        .o_dbg_data (dbg_data),
        .i_we       (r_e_valid),
        .i_wr_idx   (r_e_rd),
        .i_wr_data  (add_s)
    );

`ifdef ADDER_BYPASS_EN
    // The bank still holds the old value during write-back, so take the sum directly.
    always_comb begin
        w_opnd_a = w_bank_a;
        w_opnd_b = w_bank_b;
        if (r_e_valid && (r_e_rd != '0) && (r_e_rd == in_ra)) begin
            w_opnd_a = add_s;
        end
        if (r_e_valid && (r_e_rd != '0) && (r_e_rd == in_rb)) begin
            w_opnd_b = add_s;
        end
    end

    assign in_ready = !hold;
`else
    logic w_reads_regs;
    logic w_hazard;

    assign w_reads_regs = (in_op == OP_ADD) || (in_op == OP_SUB);
    assign w_hazard     = r_e_valid && (r_e_rd != '0) && w_reads_regs &&
                          ((in_ra == r_e_rd) || (in_rb == r_e_rd));

    assign w_opnd_a = w_bank_a;
    assign w_opnd_b = w_bank_b;
    assign in_ready = !hold && !w_hazard;
`endif

    assign w_accept  = in_valid && in_ready;
    assign w_is_movi = (in_op == OP_MOVI);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_e_valid <= 1'b0;
            r_e_sub   <= 1'b0;
            r_e_rd    <= '0;
            r_e_a     <= '0;
            r_e_b     <= '0;
        end else begin
            r_e_valid <= w_accept && (in_op != OP_NOP);
            if (w_accept) begin
                r_e_rd  <= in_rd;
                r_e_sub <= (in_op == OP_SUB);
                r_e_a   <= w_is_movi ? '0 : w_opnd_a;
                r_e_b   <= w_is_movi ? in_imm : w_opnd_b;
            end
        end
    end

    // MOVI runs as 0 + imm, which can never overflow, so the ADD rule already yields 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_zero <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (r_e_valid) begin
            r_zero <= (add_s == '0);
            r_ovf  <= signed_ovf(r_e_a[N-1], r_e_b[N-1], add_s[N-1], r_e_sub);
        end
    end

    assign add_a   = r_e_a;
    assign add_b   = r_e_b;
    assign add_sub = r_e_sub;
    assign zero    = r_zero;
    assign ovf     = r_ovf;

endmodule

// File: tb/tb_adder_issue_writeback.sv
// Randomized bench for adder_issue_writeback against a program-order architectural model;
// the external adder is modelled behaviourally.
module tb_adder_issue_writeback;

`ifdef ADDER_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct packed {
        logic       ready;
        logic [3:0] dbg;
        logic       zero;
        logic       ovf;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] in_op = 2'd0;
    logic [2:0] in_rd = 3'd0;
    logic [2:0] in_ra = 3'd0;
    logic [2:0] in_rb = 3'd0;
    logic [3:0] in_imm = 4'd0;
    logic       hold = 1'b0;
    logic [3:0] add_a;
    logic [3:0] add_b;
    logic       add_sub;
    logic [3:0] add_s;
    logic       zero;
    logic       ovf;
    logic [2:0] dbg_sel = 3'd0;
    logic [3:0] dbg_data;

    int n_checks = 0;
    int n_pass   = 0;

    // Architectural state: arch is program order, vis is what the bank shows.
    logic [3:0] arch [8];
    logic [3:0] vis  [8];
    logic       m_zero, m_ovf;
    logic       p_valid, p_known, p_sub, p_zero, p_ovf;
    logic [2:0] p_rd;
    logic [3:0] p_a, p_b, p_res;

    adder_issue_writeback #(
        .N (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_rd    (in_rd),
        .in_ra    (in_ra),
        .in_rb    (in_rb),
        .in_imm   (in_imm),
        .hold     (hold),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_sub  (add_sub),
        .add_s    (add_s),
        .zero     (zero),
        .ovf      (ovf),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data)
    );

    assign add_s = add_sub ? 4'(add_a - add_b) : 4'(add_a + add_b);

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic int sv4(input logic [3:0] v);
        return v[3] ? int'(v) - 16 : int'(v);
    endfunction

    function automatic logic hazard(input logic [1:0] op, input logic [2:0] ra,
                                    input logic [2:0] rb);
        return !BYPASS && p_valid && (p_rd != 3'd0) && (op == 2'd1 || op == 2'd2) &&
               (ra == p_rd || rb == p_rd);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            arch[i] = 4'd0;
            vis[i]  = 4'd0;
        end
        m_zero = 0; m_ovf = 0;
        p_valid = 0; p_known = 1; p_sub = 0; p_zero = 0; p_ovf = 0;
        p_rd = 3'd0; p_a = 4'd0; p_b = 4'd0; p_res = 4'd0;
    endtask

    task automatic model_edge(input logic acc, input logic [1:0] op, input logic [2:0] rd,
                              input logic [2:0] ra, input logic [2:0] rb,
                              input logic [3:0] imm);
        int sum;
        if (p_valid) begin
            if (p_rd != 3'd0) vis[p_rd] = p_res;
            m_zero = p_zero;
            m_ovf  = p_ovf;
        end
        p_valid = 0;
        if (acc) begin
            if (op == 2'd0) begin
                p_known = 0;
            end else begin
                p_known = 1;
                p_valid = 1;
                p_rd    = rd;
                p_sub   = (op == 2'd2);
                p_a     = (op == 2'd3) ? 4'd0 : arch[ra];
                p_b     = (op == 2'd3) ? imm : arch[rb];
                p_res   = p_sub ? 4'(p_a - p_b) : 4'(p_a + p_b);
                sum     = p_sub ? sv4(p_a) - sv4(p_b) : sv4(p_a) + sv4(p_b);
                p_ovf   = (op != 2'd3) && (sum < -8 || sum > 7);
                p_zero  = (p_res == 4'd0);
                if (rd != 3'd0) arch[rd] = p_res;
            end
        end
    endtask

    // One clock cycle: drive at posedge+1, sample at the negedge, advance the model at posedge.
    task automatic step(input logic v, input logic [1:0] op, input logic [2:0] rd,
                        input logic [2:0] ra, input logic [2:0] rb, input logic [3:0] imm,
                        input logic h, input int dsel, output logic acc, output obs_t o);
        logic [2:0] sel;
        sel = (dsel < 0) ? 3'($urandom_range(0, 7)) : 3'(dsel);
        in_valid = v; in_op = op; in_rd = rd; in_ra = ra; in_rb = rb; in_imm = imm;
        hold = h; dbg_sel = sel;
        #4;
        o.ready = in_ready; o.dbg = dbg_data; o.zero = zero; o.ovf = ovf;
        check("in_ready", in_ready, !h && !hazard(op, ra, rb));
        check("dbg_data", dbg_data, vis[sel]);
        check("zero", zero, m_zero);
        check("ovf", ovf, m_ovf);
        if (p_known) begin
            check("add_a", add_a, p_a);
            check("add_b", add_b, p_b);
            check("add_sub", add_sub, p_sub);
        end
        acc = v && in_ready;
        @(posedge clk);
        model_edge(acc, op, rd, ra, rb, imm);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] ra,
                         input logic [2:0] rb, input logic [3:0] imm, output int cyc);
        logic acc;
        obs_t o;
        cyc = 0;
        acc = 0;
        while (!acc && cyc < 4) begin
            step(1'b1, op, rd, ra, rb, imm, 1'b0, -1, acc, o);
            cyc++;
        end
        check("issue_accept", acc, 1'b1);
    endtask

    // Two idle cycles so the last request has written back, then observe register r.
    task automatic drain(input int r, output obs_t o);
        logic acc;
        step(1'b0, 2'd0, 3'd0, 3'd0, 3'd0, 4'd0, 1'b0, -1, acc, o);
        step(1'b0, 2'd0, 3'd0, 3'd0, 3'd0, 4'd0, 1'b0, r, acc, o);
    endtask

    task automatic do_reset();
        reset = 1; in_valid = 0; hold = 0;
        #1;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            dbg_sel = 3'(i);
            #1;
            check("rst_dbg", dbg_data, 4'd0);
        end
        check("rst_add_a", add_a, 4'd0);
        check("rst_add_b", add_b, 4'd0);
        check("rst_add_sub", add_sub, 1'b0);
        check("rst_zero", zero, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    initial begin
        int c1, c2, c3;
        logic acc;
        obs_t o;

        @(posedge clk);
        #1;
        do_reset();

        // 5 + 3 wraps to -8 in 4-bit signed
        issue(2'd3, 3'd1, 3'd0, 3'd0, 4'd5, c1);
        issue(2'd3, 3'd2, 3'd0, 3'd0, 4'd3, c1);
        issue(2'd1, 3'd3, 3'd1, 3'd2, 4'd0, c1);
        drain(3, o);
        check("add_r3", o.dbg, 4'd8);
        check("add_r3_ovf", o.ovf, 1'b1);
        check("add_r3_zero", o.zero, 1'b0);

        // Dependent chain: bubbles only without forwarding
        issue(2'd3, 3'd1, 3'd0, 3'd0, 4'd2, c1);
        issue(2'd1, 3'd1, 3'd1, 3'd1, 4'd0, c2);
        issue(2'd1, 3'd1, 3'd1, 3'd1, 4'd0, c3);
        check("chain_cycles", c1 + c2 + c3, BYPASS ? 3 : 5);
        drain(1, o);
        check("chain_r1", o.dbg, 4'd8);

        issue(2'd2, 3'd4, 3'd2, 3'd2, 4'd0, c1);
        drain(4, o);
        check("sub_r4", o.dbg, 4'd0);
        check("sub_r4_zero", o.zero, 1'b1);
        check("sub_r4_ovf", o.ovf, 1'b0);

        // -8 - 1 overflows to +7
        issue(2'd3, 3'd1, 3'd0, 3'd0, 4'd8, c1);
        issue(2'd3, 3'd2, 3'd0, 3'd0, 4'd1, c1);
        issue(2'd2, 3'd6, 3'd1, 3'd2, 4'd0, c1);
        drain(6, o);
        check("sub_r6", o.dbg, 4'd7);
        check("sub_r6_ovf", o.ovf, 1'b1);

        issue(2'd3, 3'd0, 3'd0, 3'd0, 4'd7, c1);
        drain(0, o);
        check("r0_stays_zero", o.dbg, 4'd0);
        check("r0_flag_zero", o.zero, 1'b0);
        check("r0_flag_ovf", o.ovf, 1'b0);
        issue(2'd1, 3'd5, 3'd0, 3'd0, 4'd0, c1);
        drain(5, o);
        check("r5_from_r0", o.dbg, 4'd0);
        check("r5_zero", o.zero, 1'b1);

        // Hold: pending MOVI retires, then flags stay put while nothing is accepted
        issue(2'd3, 3'd7, 3'd0, 3'd0, 4'd3, c1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'd1, 3'd6, 3'd7, 3'd7, 4'd0, 1'b1, -1, acc, o);
            check("hold_ready", o.ready, 1'b0);
            if (i > 0) check("hold_zero", o.zero, 1'b0);
        end
        step(1'b1, 2'd1, 3'd6, 3'd7, 3'd7, 4'd0, 1'b0, -1, acc, o);
        check("release_accept", o.ready, 1'b1);
        drain(6, o);
        check("hold_r6", o.dbg, 4'd6);

        for (int i = 0; i < 300; i++) begin
            if (i == 150) begin
                step(1'b1, 2'd3, 3'd3, 3'd0, 3'd0, 4'd9, 1'b0, -1, acc, o);
                do_reset();
            end
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                 $urandom_range(0, 4) == 0, -1, acc, o);
        end
        drain(0, o);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/adder_issue_writeback.md
# adder_issue_writeback

Issue/write-back stage wrapped around the ripple-carry adder/subtractor. Accepts register-level ADD/SUB/MOVI requests over a valid/ready handshake and reads operands from an internal 8-entry register bank. It drives the adder's A, B and sub inputs from a registered execute stage, then writes the adder's S output back to the bank one cycle later while updating the zero and overflow flags. It sits directly upstream and downstream of the adder: it feeds the adder's inputs and consumes its sum.

## Interface
- N, 4: data width; must match the adder instance.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted on the edge where in_valid && in_ready.
- in_op  in  2  opcode: 0 NOP, 1 ADD, 2 SUB, 3 MOVI.
- in_rd, in_ra, in_rb  in  3 each  destination and source register indices.
- in_imm  in  N  immediate for MOVI.
- hold  in  1  upstream stall; forces in_ready low.
- add_a, add_b  out  N each  to adder A, B.
- add_sub  out  1  to adder sub.
- add_s  in  N  from adder S (combinational, same cycle).
- zero, ovf  out  1 each  registered flags.
- dbg_sel  in  3  debug read index.
- dbg_data  out  N  combinational read of the register selected by dbg_sel.

## Operation
- Register bank: R0..R7, N bits each. R0 always reads 0, and writes to it are discarded.
- Accept: on the edge where in_valid && in_ready, the execute register (E) loads:
  - e_valid = (op != NOP)
  - e_rd, e_sub = (op == SUB)
  - e_a = (op == MOVI) ? 0 : operand(ra)
  - e_b = (op == MOVI) ? imm : operand(rb)
- No accept: E loads e_valid = 0; other E fields hold.
- Adder drive:
  - add_a = e_a, add_b = e_b, add_sub = e_sub.
  - The adder inverts B itself; this block never pre-inverts.
- Write-back: on the edge where e_valid = 1:
  - R[e_rd] <= add_s, unless e_rd = 0.
  - zero <= (add_s == 0).
  - ovf <= signed overflow computed from sign bits, with sa = e_a[N-1], sb = e_b[N-1], ss = add_s[N-1]:
    - ADD: sa == sb && ss != sa.
    - SUB: sa != sb && ss != sa.
    - MOVI: 0.
  - Flags update even when rd = 0.
  - With e_valid = 0, the flags hold.
- Result width: add_s is N bits, and the carry-out is discarded (wrap-around modulo 2^N).
- operand(r):
  - r = 0 → 0.
  - e_valid && e_rd == r && r != 0 → forwarded (see Configuration).
  - Otherwise → R[r].
- in_ready = !hold (and the interlock term when forwarding is compiled out).
- Write-back is never stalled: E always retires in the cycle after acceptance, and hold affects only acceptance.
- Simultaneous accept and write-back to the same register: the write-back commits, and the accepted request's operand comes via the forwarding rule.

## Timing
- Reset values: R0..R7 = 0, e_valid = 0, e_a = e_b = 0, e_sub = 0, e_rd = 0, zero = 0, ovf = 0. Consequently add_a = add_b = 0 and add_sub = 0.
- Latency: request accepted at edge t → adder inputs valid during cycle t+1 → register and flags visible after edge t+1.
- Throughput: one request per cycle with forwarding.
- Reset mid-operation clears E, so any in-flight write-back is lost and the bank is zeroed.
- dbg_data is combinational from the bank. It shows the pre-write-back value during the write cycle.

## Configuration
- ADDER_BYPASS_EN defined:
  - The forwarded operand is add_s.
  - Back-to-back dependent requests issue without bubbles.
- ADDER_BYPASS_EN undefined:
  - There is no forwarding path.
  - in_ready is additionally forced low while e_valid && e_rd != 0 && the pending request reads e_rd (ra for ADD/SUB, or rb for ADD/SUB).
  - The result is a single-cycle interlock; operands are then read from the bank after write-back.

## Structure
- Shared package nanoproc_pkg:
  - Opcode constants OP_NOP, OP_ADD, OP_SUB, OP_MOVI.
  - Register-index width REG_AW = 3.
  - Register count NUM_REGS = 8.
- Sub-module register_bank: 8×N storage with R0 tied to zero, two operand read ports, one debug read port and one write port, on asynchronous active-high reset.
- Top level: E register, forwarding/interlock logic and flag logic. The adder is instantiated outside this block.

## Test plan
- Reset: assert reset mid-stream → all dbg_data reads 0, zero = ovf = 0, add_a = add_b = 0, add_sub = 0.
- MOVI R1,5 then MOVI R2,3 then ADD R3,R1,R2 → R3 = 8, ovf = 1 (5+3 overflows 4-bit signed), zero = 0.
- Dependent chain MOVI R1,2; ADD R1,R1,R1; ADD R1,R1,R1 issued back-to-back → with ADDER_BYPASS_EN, R1 = 8 after 3 accepts in 3 cycles. Without it, each dependent request sees in_ready low for one cycle, and the final R1 = 8.
- SUB R4,R2,R2 with R2 = 3 → R4 = 0, zero = 1, ovf = 0. SUB with R1 = 0x8 (−8) and R2 = 1 → result 0x7, ovf = 1.
- Writes to R0 (MOVI R0,7) → dbg_data for R0 stays 0, flags update (zero = 0); the dependent ADD R5,R0,R0 gives R5 = 0.
- hold high with in_valid high for 3 cycles → no accept, E retires the pending op, flags unchanged after that. On hold release, the request is accepted on the next edge.
